// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode-stage hazard logic: opcodes, stall causes,
// FSM states and the load tracker entry format.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDZ = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_NOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_LHB  = 4'hA,
        OP_LLB  = 4'hB,
        OP_B    = 4'hC,
        OP_JAL  = 4'hD,
        OP_JR   = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    localparam logic [1:0] REASON_NONE = 2'd0;
    localparam logic [1:0] REASON_LOAD = 2'd1;
    localparam logic [1:0] REASON_MEM  = 2'd2;

    // State codes equal the stall_reason they report.
    typedef enum logic [1:0] {
        RUN      = REASON_NONE,
        LD_STALL = REASON_LOAD,
        MEM_WAIT = REASON_MEM
    } state_t;

    typedef struct packed {
        logic       is_load;
        logic [3:0] dest;
    } trk_entry_t;

    localparam trk_entry_t TRK_EMPTY = '0;

endpackage

// File: rtl/src_decode.sv
// Source-register decode: which register fields an instruction reads.
// Pure combinational.
module src_decode
    import isa_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  rs_a,
    output logic [3:0]  rs_b,
    output logic        use_a,
    output logic        use_b
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        rs_a  = instr[7:4];
        rs_b  = instr[3:0];
        use_a = 1'b0;
        use_b = 1'b0;
        case (opcode_t'(instr[15:12]))
            OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_LW, OP_JR: begin
                use_a = 1'b1;
            end
            OP_SW: begin
                // Store reads its data register and its base register.
                rs_a  = instr[11:8];
                rs_b  = instr[7:4];
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_LHB: begin
                rs_a  = instr[11:8];
                use_a = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall controller: load-use interlock against a short tracker of
// issued loads, memory-wait freeze, bubble insertion and a saturating stall counter.
module hazard_stall_ctrl
    import isa_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int R0_ZERO  = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic             mem_busy,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       stall_reason,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [3:0] rs_a;
    logic [3:0] rs_b;
    logic       use_a;
    logic       use_b;

    src_decode u_src_decode (
        .instr (id_instr),
        .rs_a  (rs_a),
        .rs_b  (rs_b),
        .use_a (use_a),
        .use_b (use_b)
    );

    trk_entry_t trk [LOAD_LAT];
    trk_entry_t entry_in;
    state_t     state;
    state_t     cause;
    logic       hazard;
    logic       raw_stall;
    logic       raw_bubble;

    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                if (trk[i].is_load && !(R0_ZERO != 0 && trk[i].dest == 4'd0) &&
                    ((use_a && trk[i].dest == rs_a) || (use_b && trk[i].dest == rs_b)))
                    hazard = 1'b1;
            end
        end
    end

    assign raw_stall  = mem_busy | (hazard & ~flush);
    assign raw_bubble = ~mem_busy & (flush | hazard);

    // Mealy FSM: the cause of the current cycle is the state being entered.
    always_comb begin
        cause = RUN;
        case (state)
            MEM_WAIT: cause = mem_busy ? MEM_WAIT : ((hazard && !flush) ? LD_STALL : RUN);
            LD_STALL: cause = mem_busy ? MEM_WAIT : ((hazard && !flush) ? LD_STALL : RUN);
            default:  cause = mem_busy ? MEM_WAIT : ((hazard && !flush) ? LD_STALL : RUN);
        endcase
    end

    assign stall        = rst_n & raw_stall;
    assign bubble       = rst_n & raw_bubble;
    assign stall_reason = rst_n ? cause : REASON_NONE;

    always_comb begin
        entry_in = TRK_EMPTY;
        if (!raw_bubble && id_valid) begin
            entry_in.is_load = (opcode_t'(id_instr[15:12]) == OP_LW);
            entry_in.dest    = id_instr[11:8];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every read sees pre-edge values.
        if (!rst_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            // NOTE: the tracker is a tiny register array that must start empty, so it is reset.
            for (int i = 0; i < LOAD_LAT; i++) trk[i] <= TRK_EMPTY;
        end else begin
            state <= cause;
            if (cnt_clr)
                stall_cnt <= '0;
            else if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!mem_busy) begin
                trk[0] <= entry_in;
                for (int i = 1; i < LOAD_LAT; i++) trk[i] <= trk[i-1];
            end
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, meaning load-use stall cycles needed (legal 1..3).
REQ-002 SHALL have parameter R0_ZERO, default 1, meaning when 1, register 0 never causes a hazard.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port id_instr  input  16  instruction currently in decode.
REQ-007 SHALL have port id_valid  input  1  id_instr holds a real instruction.
REQ-008 SHALL have port mem_busy  input  1  data memory not ready; freeze the whole pipe.
REQ-009 SHALL have port flush  input  1  branch/jump redirect; kill the decode instruction.
REQ-010 SHALL have port cnt_clr  input  1  clear the stall counter.
REQ-011 SHALL have port stall  output  1  hold PC and IF/ID this cycle.
REQ-012 SHALL have port bubble  output  1  insert a NOP into ID/EX this cycle.
REQ-013 SHALL have port stall_reason  output  2  0 none, 1 load-use, 2 mem wait.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 SHALL decode sources from id_instr[15:12]: add/addz/sub/and/nor (0-4) read [7:4] and [3:0]; sll/srl/sra/lw (5-8) read [7:4]; sw (9) reads [11:8] and [7:4]; lhb (A) reads [11:8]; jr (E) reads [7:4]; llb, b, jal, hlt read nothing.
REQ-016 SHALL keep a LOAD_LAT-deep tracker shift register; each entry is {is_load, dest[3:0]}; entry 0 is the youngest issued instruction.
REQ-017 SHALL assert hazard when id_valid is 1 and any tracker entry has is_load=1 and a dest equal to a source read by id_instr; when R0_ZERO=1, dest 0 is excluded.
REQ-018 SHALL compute stall combinationally in the same cycle: stall = mem_busy | (hazard & ~flush); latency is 0.
REQ-019 SHALL drive bubble = ~mem_busy & (flush | hazard).
REQ-020 SHALL use priority mem_busy > flush > hazard when inputs occur together.
REQ-021 SHALL freeze the tracker (no shift) in any cycle with mem_busy=1.
REQ-022 SHALL, otherwise, shift the tracker one place each cycle, loading entry 0 as follows: bubble=1 gives {0,0}; id_valid=0 gives {0,0}; else {opcode==lw, id_instr[11:8]}.
REQ-023 SHALL, from REQ-022, stall a consumer placed k cycles behind a lw for exactly max(0, LOAD_LAT-k+1) cycles, where k=1 means adjacent.
REQ-024 SHALL implement an FSM with states RUN, LD_STALL, MEM_WAIT, where stall_reason encodes the current cycle's cause.
REQ-025 SHALL enter MEM_WAIT whenever mem_busy=1, and leave it the cycle mem_busy falls, re-evaluating hazard then.
REQ-026 SHALL enter LD_STALL on hazard without mem_busy, and return to RUN when hazard clears.
REQ-027 SHALL set stall_reason = 2 in MEM_WAIT, 1 in LD_STALL, and 0 in RUN.
REQ-028 SHALL leave tracker entries older than a flush untouched; flush affects only the decode instruction.
REQ-029 SHALL increment stall_cnt by 1 on every clock with stall=1, saturating at all-ones (no wrap).
REQ-030 SHALL give cnt_clr priority over increment, so stall_cnt reads 0 on the next clock.

Reset
REQ-031 SHALL, on a clock edge with rst_n=0, clear all tracker entries to {0,0}, set the FSM to RUN, and set stall_cnt to 0.
REQ-032 SHALL force stall, bubble, and stall_reason to 0 while rst_n=0, irrespective of other inputs.
REQ-033 SHALL discard a load-use or mem-wait stall in progress when reset is asserted; there is no residual stall after reset release.
REQ-034 SHALL require no fill state after reset: the first valid instruction is evaluated immediately.

Structure
REQ-035 SHALL place the opcode constants, the stall_reason encodings, and the FSM state encodings in the shared package isa_pkg.
REQ-036 SHALL place the source decode (instr to rs_a, rs_b, use_a, use_b) in one sub-module, src_decode, which is pure combinational.
REQ-037 SHALL hold all registers in hazard_stall_ctrl; there are no latches and one clock domain.

Verification
REQ-038 SHALL test LOAD_LAT=1: lw 0x8310 (R3 from R1), then add 0x0432 -> stall=1, bubble=1, reason=1 for 1 cycle, then add issues; stall_cnt=1.
REQ-039 SHALL test LOAD_LAT=2: the same pair gives 2 stall cycles; with one independent instr between, 1 stall cycle; with two between, 0.
REQ-040 SHALL test R0_ZERO=1: lw 0x8010 (dest R0), then add 0x0400 -> no stall; with R0_ZERO=0 -> 1 stall cycle.
REQ-041 SHALL test that sw 0x9340 after lw to R3 stalls, and that sw 0x9234 after lw to R3 also stalls (base register); b and llb after lw to R3 never stall.
REQ-042 SHALL test mem_busy held 3 cycles during a pending load-use -> reason=2 for 3 cycles with tracker frozen, then reason=1 for LOAD_LAT cycles; stall_cnt=3+LOAD_LAT.
REQ-043 SHALL test flush together with hazard -> stall=0, bubble=1; test rst_n=0 mid-stall -> outputs 0 that cycle and stall_cnt=0 after the edge; test counter saturation at CNT_W=4 -> holds 15.
